// File: rtl/prio_rr_arbiter_if.sv
// Valid/ready bundle between N_CH sources, the priority arbiter and one sink.
// Signal names are as seen from the arbiter: *_i enter it, *_o leave it, except ready_i/ready_o.
interface prio_rr_arbiter_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PRIO_W = 3
);
  localparam int unsigned CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        valid_i;
  logic [N_CH*DATA_W-1:0] data_i;
  logic [N_CH*PRIO_W-1:0] prio_i;
  logic [N_CH-1:0]        ready_i;
  logic [DATA_W-1:0]      data_o;
  logic                   valid_o;
  logic                   ready_o;
  logic [CH_W-1:0]        grant_o;

  modport slave (
    input  valid_i, data_i, prio_i, ready_o,
    output ready_i, data_o, valid_o, grant_o
  );

  modport master (
    output valid_i, data_i, prio_i, ready_o,
    input  ready_i, data_o, valid_o, grant_o
  );
endinterface

// File: rtl/prio_rr_arbiter.sv
// N-channel priority arbiter with round-robin tie-break, starvation aging and a
// registered output slot.
module prio_rr_arbiter #(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned AGE_MAX = 0
) (
  input logic              clk,
  input logic              reset_n,
  prio_rr_arbiter_if.slave bus
);
  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned AGE_W = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;

  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AGE_W-1:0]  age_q [N_CH];
  logic [AGE_W-1:0]  age_d [N_CH];

  logic              open;
  logic [PRIO_W-1:0] max_prio;
  logic [N_CH-1:0]   top, starved, cand, ready;
  logic              found, xfer;
  logic [CH_W-1:0]   gnt, idx_c;
  int unsigned       idx;
  logic [DATA_W-1:0] data_sel;

  // Winner selection: starved channels pre-empt priority, round-robin breaks ties.
  always_comb begin
    open     = !valid_q || bus.ready_o;
    max_prio = '0;
    top      = '0;
    starved  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.valid_i[k] && bus.prio_i[k*PRIO_W +: PRIO_W] > max_prio) begin
        max_prio = bus.prio_i[k*PRIO_W +: PRIO_W];
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      top[k]     = bus.valid_i[k] && (bus.prio_i[k*PRIO_W +: PRIO_W] == max_prio);
      starved[k] = (AGE_MAX > 0) && bus.valid_i[k] && (age_q[k] == AGE_W'(AGE_MAX));
    end
    cand  = (|starved) ? starved : top;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    idx_c = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CH_W'(idx);
      if (!found && cand[idx_c]) begin
        found = 1'b1;
        gnt   = idx_c;
      end
    end
    ready = '0;
    if (reset_n && open && (|bus.valid_i) && found) ready[gnt] = 1'b1;
    xfer = |ready;
  end

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ready[k]) data_sel = bus.data_i[k*DATA_W +: DATA_W];
    end
    valid_d  = valid_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (open) valid_d = xfer;
    if (xfer) begin
      data_d   = data_sel;
      grant_d  = gnt;
      rr_ptr_d = gnt;
    end
    // Only lost arbitrations age a channel; a closed slot freezes every counter.
    for (int k = 0; k < N_CH; k++) begin
      age_d[k] = age_q[k];
      if (!bus.valid_i[k]) begin
        age_d[k] = '0;
      end else if (xfer && gnt == CH_W'(k)) begin
        age_d[k] = '0;
      end else if (xfer && age_q[k] < AGE_W'(AGE_MAX)) begin
        age_d[k] = age_q[k] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= CH_W'(N_CH - 1);
      for (int k = 0; k < N_CH; k++) age_q[k] <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < N_CH; k++) age_q[k] <= age_d[k];
    end
  end

  assign bus.ready_i = ready;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.grant_o = grant_q;
endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_prio_rr_arbiter;
  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 3;

  typedef struct packed {
    logic [2:0]  g;
    logic [31:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel;
  logic [N-1:0]  vld;
  logic [DW-1:0] dat [N];
  logic [PW-1:0] pri [N];
  logic          rdy;
  logic [N*DW-1:0] dat_flat;
  logic [N*PW-1:0] pri_flat;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  beat_t e;
  beat_t hold_b;
  logic  hold_v = 1'b0;
  logic [7:0] oh;
  int    g;

  always #5 clk = ~clk;

  always_comb begin
    dat_flat = '0;
    pri_flat = '0;
    for (int k = 0; k < N; k++) begin
      dat_flat[k*DW +: DW] = dat[k];
      pri_flat[k*PW +: PW] = pri[k];
    end
  end

  prio_rr_arbiter_if #(.N_CH(N), .DATA_W(DW), .PRIO_W(PW)) if0 ();
  prio_rr_arbiter_if #(.N_CH(N), .DATA_W(DW), .PRIO_W(PW)) if1 ();

  assign if0.valid_i = vld;
  assign if0.data_i  = dat_flat;
  assign if0.prio_i  = pri_flat;
  assign if0.ready_o = rdy;
  assign if1.valid_i = vld;
  assign if1.data_i  = dat_flat;
  assign if1.prio_i  = pri_flat;
  assign if1.ready_o = rdy;

  prio_rr_arbiter #(.N_CH(N), .DATA_W(DW), .PRIO_W(PW), .AGE_MAX(0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0.slave)
  );

  prio_rr_arbiter #(.N_CH(N), .DATA_W(DW), .PRIO_W(PW), .AGE_MAX(4)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if1.slave)
  );

  logic [N-1:0]  m_ready_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic [2:0]    m_grant_o;
  assign m_ready_i = sel ? if1.ready_i : if0.ready_i;
  assign m_valid_o = sel ? if1.valid_o : if0.valid_o;
  assign m_data_o  = sel ? if1.data_o  : if0.data_o;
  assign m_grant_o = sel ? if1.grant_o : if0.grant_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [31:0] d);
    exp_q.push_back({ch[2:0], d});
  endtask

  // Monitor: pops on each accepted output beat, and checks a stalled beat stays put.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 64'(m_valid_o), 64'd1);
          check("hold_beat", 64'({m_grant_o, m_data_o}), 64'(hold_b));
        end
        if (m_valid_o && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got grant %0d data %0h, expected none",
                     m_grant_o, m_data_o);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'({m_grant_o, m_data_o}), 64'(e));
          end
          hold_v = 1'b0;
        end else if (m_valid_o) begin
          hold_v = 1'b1;
          hold_b = {m_grant_o, m_data_o};
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sel     = 1'b0;
    rdy     = 1'b0;
    vld     = '0;
    for (int k = 0; k < N; k++) begin
      dat[k] = 32'hD000_0000 | 32'(k);
      pri[k] = '0;
    end

    // Reset state, with inputs active
    #2;
    vld = 8'hFF;
    #1;
    check("rst_ready", 64'(m_ready_i), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_data", 64'(m_data_o), 64'd0);
    check("rst_grant", 64'(m_grant_o), 64'd0);
    check("rst_valid_age", 64'(if1.valid_o), 64'd0);
    vld = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    // Single beat on ch3
    dat[3] = 32'h0000_00A5;
    pri[3] = 3'd2;
    vld    = 8'h08;
    rdy    = 1'b1;
    #1;
    check("single_ready", 64'(m_ready_i), 64'h08);
    push(3, 32'h0000_00A5);
    cyc();
    vld = '0;
    cyc();

    // Strict priority: ch6 (7) beats ch1 (5) every cycle
    pri[1] = 3'd5;
    pri[6] = 3'd7;
    vld    = 8'h42;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("prio_ready", 64'(m_ready_i), 64'h40);
      push(6, dat[6]);
      cyc();
    end
    vld = '0;
    cyc();

    // Backpressure: ch2 beat held 5 cycles, then drain and refill on one edge
    dat[2] = 32'h0000_2222;
    pri[2] = 3'd1;
    vld    = 8'h04;
    #1;
    check("bp_first_ready", 64'(m_ready_i), 64'h04);
    push(2, 32'h0000_2222);
    cyc();
    rdy    = 1'b0;
    dat[2] = 32'h0000_3333;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_ready", 64'(m_ready_i), 64'h00);
      cyc();
    end
    rdy = 1'b1;
    #1;
    check("bp_refill_ready", 64'(m_ready_i), 64'h04);
    push(2, 32'h0000_3333);
    cyc();
    vld = '0;
    cyc();

    // Reset while a stalled beat is held: dropped without a clock edge
    dat[0] = 32'h0000_0BAD;
    vld    = 8'h01;
    rdy    = 1'b0;
    #1;
    check("pre_rst_ready", 64'(m_ready_i), 64'h01);
    cyc();
    #1;
    check("pre_rst_valid", 64'(m_valid_o), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid_o), 64'd0);
    check("mid_rst_ready", 64'(m_ready_i), 64'd0);
    cyc();
    cyc();
    reset_n = 1'b1;

    // Round-robin among 8 equal-priority channels, starting from ch0 after reset
    for (int k = 0; k < N; k++) pri[k] = 3'd3;
    vld = 8'hFF;
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      g  = i % 8;
      oh = 8'd1 << g;
      #1;
      check("rr_ready", 64'(m_ready_i), 64'(oh));
      push(g, dat[g]);
      cyc();
    end
    vld = '0;
    cyc();
    cyc();

    // Aging (AGE_MAX=4): low-priority ch0 wins every fifth beat
    sel    = 1'b1;
    pri[0] = 3'd0;
    pri[5] = 3'd7;
    vld    = 8'h21;
    for (int i = 0; i < 15; i++) begin
      g  = (i % 5 == 4) ? 0 : 5;
      oh = 8'd1 << g;
      #1;
      check("age_ready", 64'(m_ready_i), 64'(oh));
      push(g, dat[g]);
      cyc();
    end
    vld = '0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Parametrised N-channel priority arbiter with round-robin tie-breaking, starvation aging and a registered output stage. It merges `N_CH` valid/ready source channels, each carrying data plus a per-beat priority, onto one valid/ready sink. It is the generalised successor of the fixed 8-channel priority merge in the top-level datapath, and drops in where that block sat.

## Interface
- `N_CH`, 8, number of input channels (≥2); `CH_W = $clog2(N_CH)`
- `DATA_W`, 32, data width per channel
- `PRIO_W`, 3, priority width; larger value = higher priority
- `AGE_MAX`, 0, lost-arbitration count that promotes a waiting channel; 0 disables aging
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `valid_i`  in  N_CH  per-channel beat valid
- `data_i`  in  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- `prio_i`  in  N_CH*PRIO_W  channel k priority, bits [k*PRIO_W +: PRIO_W]
- `ready_i`  out  N_CH  per-channel accept; at most one bit set (one-hot or zero)
- `data_o`  out  DATA_W  registered output data
- `valid_o`  out  1  output beat valid
- `ready_o`  in  1  sink accept
- `grant_o`  out  CH_W  source channel of the beat in `data_o`

## Operation
- Slot open: `open = !valid_o || ready_o`. Arbitration runs every cycle; a grant takes effect only when `open`.
- Candidate set:
  - If `AGE_MAX>0` and any valid channel has `age[k]==AGE_MAX`, candidates are the starved valid channels only.
  - Otherwise candidates are the valid channels whose `prio_i` equals the maximum `prio_i` among valid channels.
- Tie-break within the candidates: round-robin, searching from `rr_ptr+1` upward with wrap modulo `N_CH`. The first candidate found is winner `g`.
- `ready_i[g] = open && |valid_i`; all other bits are 0. `ready_i` is combinational from `valid_i`, `prio_i` and `ready_o`. Sources must not make `valid_i` depend on `ready_i`.
- Transfer on channel g (`valid_i[g] && ready_i[g]`):
  - next edge: `data_o<=data_i[g]`, `grant_o<=g`, `valid_o<=1`, `rr_ptr<=g`.
- Open slot with no valid input: `valid_o<=0`; `data_o` and `grant_o` hold.
- `rr_ptr` updates only on a transfer.
- Age counters (width `$clog2(AGE_MAX+1)`), per channel k, on each edge:
  - `valid_i[k]` low → 0
  - granted → 0
  - valid, not granted, and a transfer to another channel occurred → increment, saturating at `AGE_MAX`
  - otherwise hold (slot closed, backpressure does not age)
- Aging promotes the channel above all priorities. It does not alter `prio_i`.

## Timing
- Reset (asynchronous assert, synchronous-edge release): `valid_o=0`, `data_o=0`, `grant_o=0`, `rr_ptr=N_CH-1` (so channel 0 wins the first tie), all ages 0. `ready_i=0` while `reset_n` is low.
- Latency: input accept to `valid_o` = 1 cycle.
- Throughput: 1 beat/cycle with `ready_o` held high.
- Backpressure: `valid_o=1 && ready_o=0` → `ready_i=0`; `data_o`, `grant_o` and `valid_o` are stable until accepted.
- Simultaneous drain and refill: `valid_o && ready_o` with a valid input → new beat loads on the same edge, with no bubble.
- A priority change on a not-yet-granted channel takes effect the same cycle.
- Reset mid-transfer: the held beat is dropped and `valid_o` falls immediately. The source sees no completed handshake and retains the beat.
- Single valid channel: always granted when `open`, regardless of priority or age.

## Test plan
- **Single beat:** ch3 valid, `data=0xA5`, prio 2, `ready_o=1` → `ready_i=0x08` same cycle; next cycle `valid_o=1`, `data_o=0xA5`, `grant_o=3`.
- **Priority:** `AGE_MAX=0`; ch1 prio 5 and ch6 prio 7, both continuously valid → `grant_o=6` every cycle, `ready_i[1]` never set.
- **Round-robin tie:** all 8 channels valid, prio 3, `ready_o=1` → `grant_o` sequence 0,1,2,…,7,0,1, one beat per cycle.
- **Backpressure:** beat from ch2 held, `ready_o=0` for 5 cycles → `data_o`/`grant_o` stable and `ready_i=0`; `ready_o=1` → next beat loads on the same edge.
- **Aging:** `AGE_MAX=4`; ch0 prio 0 and ch5 prio 7, both continuously valid → grants 5,5,5,5,0 repeating.
- **Reset mid-operation:** drop `reset_n` while `valid_o=1` → `valid_o=0` without a clock edge; after release with all channels tied, first grant is ch0.
